// File: rtl/serial_subtractor.sv
//-----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned/two's-complement subtractor. Computes A - B one bit per
//   clock, LSB first, using a single borrow flip-flop. Operands are captured on
//   the accept edge; the registered result is held until the next operation
//   completes.
//
// Parameters
//   WIDTH  operand/result width (2..32)
//   CNT_W  bit-counter width, 2**CNT_W > WIDTH
//
// Ports
//   clk_in      clock, rising edge
//   rst_in      synchronous active-high reset
//   start_in    start request, sampled only in IDLE
//   a_in        minuend
//   b_in        subtrahend
//   busy_out    high while an operation is running
//   done_out    one-cycle pulse when a new result is written
//   diff_out    (A - B) mod 2**WIDTH
//   borrow_out  1 when A < B (unsigned)
//   ovf_out     signed overflow of A - B
//
// Build option
//   SERIAL_SUBTRACTOR_OVF_EN  when defined, ovf_out reports signed overflow;
//                             otherwise ovf_out is tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start_in; result registers hold last answer
// ST_RUN  | one difference bit produced per edge, WIDTH edges total
//-----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             ovf_out
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_pd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_res;
    logic             r_done;

    logic             w_d;
    logic             w_borrow_nxt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_BIT) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs.
    assign w_d          = r_sa[0] ^ r_sb[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sa         <= '0;
            r_sb         <= '0;
            r_pd         <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= '0;
            r_borrow_res <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_sa     <= a_in;
                r_sb     <= b_in;
                r_pd     <= '0;
                r_cnt    <= '0;
                r_borrow <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_sa     <= r_sa >> 1;
                r_sb     <= r_sb >> 1;
                r_pd     <= {w_d, r_pd[WIDTH-1:1]};
                r_cnt    <= r_cnt + CNT_W'(1);
                r_borrow <= w_borrow_nxt;
                if (w_last) begin
                    // Final bit goes straight into the result alongside the
                    // already-shifted partial difference.
                    r_diff       <= {w_d, r_pd[WIDTH-1:1]};
                    r_borrow_res <= w_borrow_nxt;
                end
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand MSBs are shifted out during the run, so keep copies.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_msb <= a_in[WIDTH-1];
                r_b_msb <= b_in[WIDTH-1];
            end
            if (w_last) begin
                r_ovf <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
            end
        end
    end

    assign ovf_out = r_ovf;
`else
    assign ovf_out = 1'b0;
`endif

    assign busy_out   = (r_state == ST_RUN);
    assign done_out   = r_done;
    assign diff_out   = r_diff;
    assign borrow_out = r_borrow_res;

endmodule

// File: tb/tb_serial_subtractor.sv
//-----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed-vector bench for serial_subtractor (WIDTH = 8). Inputs are driven
//   and outputs sampled on the falling clock edge.
//-----------------------------------------------------------------------------
module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk_in;
    logic       rst_in;
    logic       start_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy_out;
    logic       done_out;
    logic [7:0] diff_out;
    logic       borrow_out;
    logic       ovf_out;

    int n_checks;
    int n_errors;

    serial_subtractor #(.WIDTH(8), .CNT_W(6)) u_dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_in   (start_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .diff_out   (diff_out),
        .borrow_out (borrow_out),
        .ovf_out    (ovf_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic [7:0] a, input logic [7:0] b);
        start_in = 1'b1;
        a_in     = a;
        b_in     = b;
    endtask

    // Called at the falling edge where start_in was just raised. Follows the
    // operation for up to 14 cycles, checking busy length, done timing, the
    // result, and optionally that the previous result stays held.
    task automatic do_op(input string tag,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input int poke_cyc,
                         input logic chain, input logic [7:0] ca, input logic [7:0] cb,
                         input logic chk_held, input logic [7:0] held);
        int busy_n;
        int done_n;
        int done_k;
        busy_n = 0;
        done_n = 0;
        done_k = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                start_in = 1'b0;
                a_in     = 8'h5A;
                b_in     = 8'hC3;
            end
            if (poke_cyc > 0 && k == poke_cyc + 1) start_in = 1'b0;
            if (busy_out) busy_n++;
            if (done_out) begin
                done_n++;
                if (done_k == 0) done_k = k;
                check_val({tag, "_diff"},   32'(diff_out),   32'(ed));
                check_val({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
                check_val({tag, "_ovf"},    32'(ovf_out),    32'(eo));
            end else if (chk_held && k <= 8) begin
                check_val({tag, "_held"}, 32'(diff_out), 32'(held));
            end
            if (poke_cyc > 0 && k == poke_cyc) begin
                start_in = 1'b1;
                a_in     = 8'h01;
                b_in     = 8'h02;
            end
            if (done_out && chain) begin
                drive_start(ca, cb);
                break;
            end
        end
        check_val({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        check_val({tag, "_done_cycle"},  32'(done_k), 32'd9);
        check_val({tag, "_done_count"},  32'(done_n), 32'd1);
    endtask

    initial begin
        int done_n;
        n_checks = 0;
        n_errors = 0;
        rst_in   = 1'b1;
        start_in = 1'b0;
        a_in     = 8'h00;
        b_in     = 8'h00;

        repeat (3) @(negedge clk_in);
        check_val("rst_busy",   32'(busy_out),   32'd0);
        check_val("rst_done",   32'(done_out),   32'd0);
        check_val("rst_diff",   32'(diff_out),   32'd0);
        check_val("rst_borrow", 32'(borrow_out), 32'd0);
        check_val("rst_ovf",    32'(ovf_out),    32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        drive_start(8'h05, 8'h03);
        do_op("5m3",   8'h02, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        drive_start(8'h03, 8'h05);
        do_op("3m5",   8'hFE, 1'b1, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        drive_start(8'h00, 8'h00);
        do_op("0m0",   8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        drive_start(8'hFF, 8'hFF);
        do_op("FFmFF", 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        drive_start(8'h80, 8'h01);
        do_op("80m01", 8'h7F, 1'b0, OVF_ON, 0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        drive_start(8'h7F, 8'hFF);
        do_op("7FmFF", 8'h80, 1'b1, OVF_ON, 0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

        // start_in pulsed during RUN is ignored; next op starts on done cycle.
        drive_start(8'h09, 8'h04);
        do_op("9m4_poke", 8'h05, 1'b0, 1'b0, 3, 1'b1, 8'h10, 8'h01, 1'b0, 8'h00);
        do_op("b2b_10m01", 8'h0F, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05);

        // Reset in the middle of a run.
        drive_start(8'hAA, 8'h55);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            if (k == 1) start_in = 1'b0;
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check_val("abort_busy",   32'(busy_out),   32'd0);
        check_val("abort_done",   32'(done_out),   32'd0);
        check_val("abort_diff",   32'(diff_out),   32'd0);
        check_val("abort_borrow", 32'(borrow_out), 32'd0);
        check_val("abort_ovf",    32'(ovf_out),    32'd0);
        done_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            if (done_out) done_n++;
        end
        check_val("abort_no_done", 32'(done_n), 32'd0);

        drive_start(8'h80, 8'h01);
        do_op("post_abort", 8'h7F, 1'b0, OVF_ON, 0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing A − B one bit per clock, LSB first, with a single borrow flip-flop. This is the inverse operation of the team's adder blocks.
- Serves as the area-lean subtract path next to the combinational adders in the arithmetic lab datapath.
- Start/done handshake; the result is held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, 6, width of the internal bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  minuend, captured on the accept edge.
- b_in  input  WIDTH  subtrahend, captured on the accept edge.
- busy_out  output  1  high while state == RUN.
- done_out  output  1  one-cycle pulse when a result is written.
- diff_out  output  WIDTH  (A − B) mod 2^WIDTH, registered.
- borrow_out  output  1  unsigned borrow; 1 iff A < B unsigned.
- ovf_out  output  1  signed overflow flag; see Optional Feature.

Behaviour:
- Reset (rst_in = 1 at an edge): state = IDLE, busy_out = 0, done_out = 0, diff_out = 0, borrow_out = 0, ovf_out = 0, internal shift registers / counter / borrow = 0.
- Reset applies in any state and aborts an operation mid-run; no done_out follows an aborted run.
- States: IDLE and RUN.
- IDLE, start_in = 1 at an edge (accept edge):
  - latch a_in → sa, b_in → sb; borrow = 0; cnt = 0; go to RUN.
- RUN, each edge:
  - d = sa[0] ^ sb[0] ^ borrow.
  - borrow' = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow).
  - Shift sa and sb right by 1; shift d into the MSB of the partial-difference register.
  - cnt = cnt + 1.
- RUN, edge where cnt == WIDTH−1 (the final bit):
  - write the complete difference to diff_out and the final borrow' to borrow_out; update ovf_out.
  - done_out = 1 for the next cycle only; go to IDLE.
- Latency: accept edge = edge 0; the result is visible and done_out = 1 in the cycle after edge WIDTH.
  - A full operation takes WIDTH+1 edges.
  - busy_out = 1 for exactly WIDTH cycles.
- start_in while RUN: ignored; the captured operands are unaffected.
- start_in during the done_out cycle: state is already IDLE, so it is accepted (back-to-back). The held result is unchanged until that operation's final edge.
- a_in/b_in changes after the accept edge have no effect.
- done_out is 0 in every cycle except the single completion cycle.
- diff_out, borrow_out and ovf_out change only at a completion edge or reset.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - At the final edge, ovf_out = (a_msb != b_msb) & (d_msb != a_msb), using the original operand MSBs and the final difference bit.
  - Held like diff_out.
- Undefined: ovf_out is constant 0 and no overflow logic is synthesized. The port remains present.

Test Plan:
- WIDTH=8; after reset → all outputs 0. Then A=5, B=3, start for 1 cycle → busy_out high 8 cycles, done_out pulses 9 cycles after the accept cycle; diff_out=0x02, borrow_out=0.
- A=3, B=5 → diff_out=0xFE, borrow_out=1. A=0, B=0 → diff_out=0x00, borrow_out=0. A=0xFF, B=0xFF → 0x00, borrow 0.
- A=0x80, B=0x01 → diff_out=0x7F, borrow_out=0, ovf_out=1 with SERIAL_SUBTRACTOR_OVF_EN, 0 without. A=0x7F, B=0xFF → diff_out=0x80, borrow_out=1, ovf_out=1 (macro on).
- Start A=9, B=4; pulse start_in with A=1, B=2 at RUN cycle 3 → result 0x05; exactly one done_out.
- Start on the done_out cycle with A=0x10, B=0x01 → previous result held for 8 more cycles, then 0x0F with a second done_out pulse.
- Start A=0xAA, B=0x55; assert rst_in at RUN cycle 4 → the next cycle has all outputs 0 and state IDLE; no done_out follows. A fresh start then completes correctly.
